// File: rtl/timing_pkg.sv
// Shared types and constants for the round countdown timer.
//
// Contents:
//   state_e         - FSM state encoding (2 bits): idle, counting, frozen, expired.
//   TickDivDefault  - clk cycles per one-second tick for a 50 MHz system clock.
//   TickDivSim      - short tick divider used by simulation benches.
//   is_busy()       - true for the states in which a round is in progress.
package timing_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned TickDivDefault = 50_000_000;
  localparam int unsigned TickDivSim     = 4;

  // A round is "in progress" whether it is counting or frozen by pause.
  function automatic logic is_busy(state_e st);
    return (st == StRun) || (st == StPause);
  endfunction

endpackage

// File: rtl/round_timer_if.sv
// Control/status bundle between the game-state controller and the round timer.
//
// Signals:
//   gameState  controller -> timer  1 = round active, 0 = abort / re-arm
//   pause      controller -> timer  level, freezes the countdown while high
//   roundTime  controller -> timer  round length in ticks, sampled at start
//   time_left  timer -> consumers   remaining ticks
//   tick       timer -> consumers   one-cycle pulse per elapsed tick
//   warn       timer -> consumers   low-time indicator
//   busy       timer -> consumers   round in progress (counting or paused)
//   cout       timer -> consumers   one-cycle expiry pulse
//
// Modports: master = controller side, slave = timer side.
interface round_timer_if #(
  parameter int unsigned ROUND_W = 4
) ();

  logic               gameState;
  logic               pause;
  logic [ROUND_W-1:0] roundTime;
  logic [ROUND_W-1:0] time_left;
  logic               tick;
  logic               warn;
  logic               busy;
  logic               cout;

  modport master (
    output gameState, pause, roundTime,
    input  time_left, tick, warn, busy, cout
  );

  modport slave (
    input  gameState, pause, roundTime,
    output time_left, tick, warn, busy, cout
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into one-tick periods.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   en    count this cycle; when low the count holds
//   clr   return the count to zero (wins over en)
//   term  high for the enabled cycle on which the count sits at TICK_DIV-1;
//         the count wraps to zero on that edge
//
// Parameters:
//   TICK_DIV  clk cycles per tick, must be >= 2
module tick_prescaler
  import timing_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tick_prescaler: TICK_DIV must be >= 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign term = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_timer.sv
// Round countdown timer for the rhythm-game core.
//
// Loads a round length when gameState rises, counts it down one tick per
// TICK_DIV clk cycles, and reports the remaining time, a per-tick pulse, a
// low-time warning, a busy flag and a one-cycle expiry pulse (cout). pause
// freezes the countdown mid-tick; dropping gameState aborts and re-arms.
// All outputs are registered.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   round_timer_if.slave (gameState, pause, roundTime in;
//         time_left, tick, warn, busy, cout out)
//
// Parameters:
//   TICK_DIV   clk cycles per tick (>= 2)
//   ROUND_W    width of roundTime / time_left; must match the interface
//   WARN_SECS  warn while 0 < time_left <= WARN_SECS during a round
//
// Build option:
//   ROUND_TIMER_AUTO_RELOAD_EN - on expiry reload roundTime and keep running
//   (cout still pulses); a zero reload value ends in DONE. Undefined: the
//   timer parks in DONE until gameState drops.
module round_timer
  import timing_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TickDivDefault,
  parameter int unsigned ROUND_W   = 4,
  parameter int unsigned WARN_SECS = 3
) (
  input logic           clk,
  input logic           rst,
  round_timer_if.slave  bus
);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] time_left_q, time_left_d;
  logic               tick_q, tick_d;
  logic               warn_q, warn_d;
  logic               busy_q, busy_d;
  logic               cout_q, cout_d;

  logic pre_en;
  logic pre_clr;
  logic pre_term;

  // Count only while a round is in progress and not paused; the PAUSE->RUN
  // cycle counts too, so the expiry slips by exactly the number of paused
  // cycles. Outside a round the prescaler is held at zero.
  assign pre_en  = bus.gameState && is_busy(state_q) && !bus.pause;
  assign pre_clr = !bus.gameState || !is_busy(state_q);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .term (pre_term)
  );

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    tick_d      = 1'b0;
    cout_d      = 1'b0;

    if (!bus.gameState) begin
      // Abort / re-arm outranks everything except reset.
      state_d     = StIdle;
      time_left_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          time_left_d = bus.roundTime;
          if (bus.roundTime != '0) begin
            state_d = StRun;
          end else begin
            state_d = StDone;
            cout_d  = 1'b1;
          end
        end

        StRun, StPause: begin
          if (bus.pause) begin
            // A pause on the terminal prescaler cycle swallows that tick;
            // the prescaler holds and delivers it on resume.
            state_d = StPause;
          end else begin
            state_d = StRun;
            if (pre_term) begin
              tick_d = 1'b1;
              if (time_left_q <= ROUND_W'(1)) begin
                cout_d = 1'b1;
`ifdef ROUND_TIMER_AUTO_RELOAD_EN
                time_left_d = bus.roundTime;
                if (bus.roundTime == '0) begin
                  state_d = StDone;
                end
`else
                time_left_d = '0;
                state_d     = StDone;
`endif
              end else begin
                time_left_d = time_left_q - ROUND_W'(1);
              end
            end
          end
        end

        StDone: begin
          // Level re-arm: stay here until gameState drops.
          time_left_d = '0;
        end

        default: begin
          state_d     = StIdle;
          time_left_d = '0;
        end
      endcase
    end

    // Derived from the next-state values so warn/busy track time_left exactly.
    busy_d = is_busy(state_d);
    warn_d = busy_d && (time_left_d != '0) && (32'(time_left_d) <= WARN_SECS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      time_left_q <= '0;
      tick_q      <= 1'b0;
      warn_q      <= 1'b0;
      busy_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      tick_q      <= tick_d;
      warn_q      <= warn_d;
      busy_q      <= busy_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.time_left = time_left_q;
  assign bus.tick      = tick_q;
  assign bus.warn      = warn_q;
  assign bus.busy      = busy_q;
  assign bus.cout      = cout_q;

endmodule
